// File: rtl/system_sysid_checker_pkg.sv
// Shared definitions for the sysid checker: FSM encoding, sysid word offsets
// and small state-mapping helpers used by the control FSM.
package system_sysid_checker_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ_ID  = 3'd1;
  localparam logic [2:0] ST_WAIT_ID = 3'd2;
  localparam logic [2:0] ST_REQ_TS  = 3'd3;
  localparam logic [2:0] ST_WAIT_TS = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  localparam int unsigned SYSID_ID_OFS = 0;
  localparam int unsigned SYSID_TS_OFS = 1;

  function automatic logic [2:0] wait_state(input logic [2:0] req_state);
    return (req_state == ST_REQ_TS) ? ST_WAIT_TS : ST_WAIT_ID;
  endfunction

  function automatic logic [2:0] after_wait(input logic [2:0] wait_st);
    return (wait_st == ST_WAIT_TS) ? ST_FIN : ST_REQ_TS;
  endfunction

  function automatic logic is_ts_phase(input logic [2:0] st);
    return (st == ST_REQ_TS) || (st == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/system_sysid_checker_timer.sv
// Per-read watchdog: clearable, saturating cycle counter whose expiry flag marks
// the TIMEOUT_CYCLES-th counted cycle of the current read.
module system_sysid_checker_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over counting; the counter holds once it reaches the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the cycles already spent, so this cycle is number count_q+1.
  assign expired_o = enable_i && (count_q >= CNT_LAST);

endmodule

// File: rtl/system_sysid_checker.sv
// Avalon-MM read master that reads the sysid ID and timestamp words, compares
// them with the expected values and reports pass/fail/timeout.
module system_sysid_checker
  import system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1392421904,
  parameter int unsigned ADDR_W         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam logic [ADDR_W-1:0] ADDR_ID = ADDR_W'(SYSID_ID_OFS);
  localparam logic [ADDR_W-1:0] ADDR_TS = ADDR_W'(SYSID_TS_OFS);

  logic [2:0]        state_q, state_d;
  logic              captured_q, captured_d;
  logic              auto_q, auto_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;

  logic accept_s;
  logic cap_s;
  logic expired_s;
  logic timer_clear_s;
  logic timer_en_s;

  assign accept_s = read_q && !avm_waitrequest;

  system_sysid_checker_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (timer_clear_s),
    .enable_i (timer_en_s),
    .expired_o(expired_s)
  );

  // Control FSM, data capture and compare.
  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    auto_d     = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    cap_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || ((AUTO_START != 0) && auto_q)) begin
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          captured_d = 1'b0;
          state_d    = ST_REQ_ID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ_ID, ST_REQ_TS: begin
        // Zero-latency fabrics may return data in the accepting cycle itself.
        if (accept_s && avm_readdatavalid) begin
          cap_s      = 1'b1;
          captured_d = 1'b1;
          state_d    = wait_state(state_q);
        end else if (expired_s) begin
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end else if (accept_s) begin
          captured_d = 1'b0;
          state_d    = wait_state(state_q);
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_ID, ST_WAIT_TS: begin
        if (captured_q) begin
          captured_d = 1'b0;
          state_d    = after_wait(state_q);
        end else if (avm_readdatavalid) begin
          cap_s   = 1'b1;
          state_d = after_wait(state_q);
        end else if (expired_s) begin
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end else begin
          state_d = state_q;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cap_s && is_ts_phase(state_q)) begin
      ts_value_d = avm_readdata;
      ts_ok_d    = (avm_readdata == EXPECTED_TS);
    end else if (cap_s) begin
      id_value_d = avm_readdata;
      id_ok_d    = (avm_readdata == EXPECTED_ID);
    end else begin
      id_value_d = id_value_q;
    end
  end

  // Timer restarts on every entry into a request state and runs through its wait.
  always_comb begin
    timer_clear_s = ((state_d == ST_REQ_ID) || (state_d == ST_REQ_TS)) && (state_d != state_q);
    timer_en_s    = (state_q == ST_REQ_ID) || (state_q == ST_WAIT_ID) ||
                    (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);
  end

  // Bus and status outputs are decoded from the next state so they leave flops.
  always_comb begin
    read_d = (state_d == ST_REQ_ID) || (state_d == ST_REQ_TS);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    if (state_d == ST_REQ_ID) begin
      addr_d = ADDR_ID;
    end else if (state_d == ST_REQ_TS) begin
      addr_d = ADDR_TS;
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      captured_q <= 1'b0;
      auto_q     <= 1'b1;
      read_q     <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      auto_q     <= auto_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_system_sysid_checker.sv
// Self-checking bench: a per-check timeline (bus activity, busy/done, final flags)
// is derived from each read's stall/latency plan and compared every cycle.
module tb_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1392421904;
  localparam int T = 8;
  localparam int N = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [0:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .ADDR_W(1),
    .TIMEOUT_CYCLES(T), .AUTO_START(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  bit          exp_read [N];
  bit          exp_addr [N];
  bit          exp_busy [N];
  bit          exp_done [N];
  bit          drv_start[N];
  bit          drv_wr   [N];
  bit          drv_rdv  [N];
  logic [31:0] drv_data [N];
  int          fin, tl_len, cur_rel;
  bit          chk_on;
  bit          exp_id_ok, exp_ts_ok, exp_to;
  logic [31:0] exp_id_val, exp_ts_val;
  int          tests, fails;

  task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s rel=%0d actual=%0h expected=%0h", name, r, act, exp);
    end
  endtask

  // One read: accepted after w stall cycles, data l cycles after acceptance.
  task automatic plan_phase(input int s, input int w, input int l, input logic [31:0] d,
                            input bit addr, output bit to, output int len);
    to  = (w + 1 + l > T);
    len = to ? T : (w + 1 + ((l > 0) ? l : 1));
    for (int k = 0; k < len; k++) begin
      if (k + 1 <= w + 1) begin
        exp_read[s+k] = 1'b1;
        exp_addr[s+k] = addr;
        drv_wr[s+k]   = (k + 1 <= w);
      end
    end
    if (w < T && s + w + l < N) begin
      drv_rdv[s+w+l]  = 1'b1;
      drv_data[s+w+l] = d;
    end
  endtask

  task automatic build(input bit use_start, input int w1, input int l1, input logic [31:0] d1,
                       input int w2, input int l2, input logic [31:0] d2, input bit noise);
    bit to1, to2;
    int len1, len2;
    for (int i = 0; i < N; i++) begin
      exp_read[i] = 0; exp_addr[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
      drv_start[i] = 0; drv_wr[i] = 0; drv_rdv[i] = 0; drv_data[i] = 32'd0;
    end
    drv_start[0] = use_start;
    exp_id_ok = 0; exp_ts_ok = 0; exp_to = 0;
    plan_phase(1, w1, l1, d1, 1'b0, to1, len1);
    if (to1) begin
      exp_to = 1;
      fin = 1 + len1;
    end else begin
      exp_id_val = d1;
      exp_id_ok  = (d1 == EXP_ID);
      plan_phase(1 + len1, w2, l2, d2, 1'b1, to2, len2);
      if (to2) begin
        exp_to = 1;
      end else begin
        exp_ts_val = d2;
        exp_ts_ok  = (d2 == EXP_TS);
      end
      fin = 1 + len1 + len2;
    end
    for (int r = 1; r <= fin; r++) exp_busy[r] = 1;
    exp_done[fin] = 1;
    tl_len = fin + 4;
    if (noise) begin
      for (int r = 1; r <= fin; r++) drv_start[r] = ($urandom_range(0, 2) == 0);
      for (int r = fin; r < tl_len; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          drv_rdv[r]  = 1'b1;
          drv_data[r] = $urandom;
        end
      end
    end
  endtask

  task automatic run(input int upto);
    for (int r = 0; r < upto; r++) begin
      start             = drv_start[r];
      avm_waitrequest   = drv_wr[r];
      avm_readdatavalid = drv_rdv[r];
      avm_readdata      = drv_data[r];
      cur_rel           = r;
      chk_on            = 1'b1;
      @(posedge clock);
      #1;
    end
    chk_on = 1'b0;
    start = 0; avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 32'd0;
  endtask

  function automatic int rnd_gap();
    int p;
    p = $urandom_range(0, 9);
    if (p < 6) return $urandom_range(0, 3);
    if (p < 9) return $urandom_range(4, 9);
    return 99;
  endfunction

  function automatic logic [31:0] rnd_word(input logic [31:0] good);
    return ($urandom_range(0, 3) == 0) ? $urandom : good;
  endfunction

  // Compare process: bus, busy and done every cycle; sticky results once idle.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("avm_read", cur_rel, avm_read, exp_read[cur_rel]);
      if (exp_read[cur_rel]) chk("avm_address", cur_rel, avm_address, exp_addr[cur_rel]);
      chk("busy", cur_rel, busy, exp_busy[cur_rel]);
      chk("done", cur_rel, done, exp_done[cur_rel]);
      if (cur_rel > fin) begin
        chk("id_ok", cur_rel, id_ok, exp_id_ok);
        chk("ts_ok", cur_rel, ts_ok, exp_ts_ok);
        chk("timeout", cur_rel, timeout, exp_to);
        chk("id_value", cur_rel, id_value, exp_id_val);
        chk("ts_value", cur_rel, ts_value, exp_ts_val);
      end
    end
  end

  initial begin
    tests = 0; fails = 0; chk_on = 0; fin = 0; cur_rel = 0;
    exp_id_val = 32'd0; exp_ts_val = 32'd0;
    reset_n = 0; start = 0; avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_read", -1, avm_read, 1'b0);
    chk("rst_busy", -1, busy, 1'b0);
    chk("rst_done", -1, done, 1'b0);
    chk("rst_flags", -1, {id_ok, ts_ok, timeout}, 3'b000);
    chk("rst_values", -1, id_value | ts_value, 32'd0);

    // Auto-started check against a zero-wait, zero-latency slave.
    build(1'b0, 0, 0, EXP_ID, 0, 0, EXP_TS, 1'b0);
    chk("pin_t1_fin", -1, fin, 5);
    reset_n = 1;
    run(tl_len);

    // Three stall cycles per read, data two cycles after acceptance.
    build(1'b1, 3, 2, EXP_ID, 3, 2, EXP_TS, 1'b0);
    chk("pin_t2_fin", -1, fin, 13);
    run(tl_len);

    // Wrong timestamp word.
    build(1'b1, 0, 0, EXP_ID, 0, 1, 32'h0000_0001, 1'b0);
    chk("pin_t3_fin", -1, fin, 5);
    run(tl_len);
    chk("t3_ts_value", -1, ts_value, 32'h0000_0001);
    chk("t3_flags", -1, {id_ok, ts_ok, timeout}, 3'b100);

    // Slave never returns data for the ID read.
    build(1'b1, 0, 99, EXP_ID, 0, 0, EXP_TS, 1'b0);
    chk("pin_t4_fin", -1, fin, 9);
    run(tl_len);
    chk("t4_flags", -1, {id_ok, ts_ok, timeout}, 3'b001);
    chk("t4_ts_value", -1, ts_value, 32'h0000_0001);

    // start while busy and spurious readdatavalid once idle.
    build(1'b1, 1, 1, 32'hDEAD_BEEF, 0, 0, EXP_TS, 1'b1);
    run(tl_len);
    chk("t5_id_value", -1, id_value, 32'hDEAD_BEEF);

    for (int n = 0; n < 40; n++) begin
      build(1'b1, rnd_gap(), rnd_gap(), rnd_word(EXP_ID),
            rnd_gap(), rnd_gap(), rnd_word(EXP_TS), 1'b1);
      run(tl_len);
    end

    // Asynchronous reset in the middle of the timestamp wait.
    build(1'b1, 0, 0, EXP_ID, 0, 0, EXP_TS, 1'b0);
    run(4);
    #2 reset_n = 0;
    #1;
    chk("t6_read", -1, avm_read, 1'b0);
    chk("t6_busy", -1, busy, 1'b0);
    chk("t6_flags", -1, {id_ok, ts_ok, timeout, done}, 4'b0000);
    chk("t6_values", -1, id_value | ts_value, 32'd0);
    exp_id_val = 32'd0; exp_ts_val = 32'd0;
    @(posedge clock);
    #1;
    build(1'b0, $urandom_range(0, 2), $urandom_range(0, 2), EXP_ID,
          $urandom_range(0, 2), $urandom_range(0, 2), EXP_TS, 1'b0);
    reset_n = 1;
    run(tl_len);
    chk("t6_auto_flags", -1, {id_ok, ts_ok, timeout}, 3'b110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
